// File: rtl/rf_pkg.sv
// Shared sizing and state encoding for the register-file write port.
package rf_pkg;
    localparam int RF_DATA_W   = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_NUM_REGS = 2 ** RF_ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_t;
endpackage

// File: rtl/decoder_5to32.sv
// Address-to-one-hot enable decoder; all outputs low when en is low.
module decoder_5to32 #(
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 2 ** ADDR_W
) (
    input  logic                en,
    input  logic [ADDR_W-1:0]   addr,
    output logic [NUM_REGS-1:0] onehot
);
    always_comb begin
        onehot = '0;
        if (en) onehot[addr] = 1'b1;
    end
endmodule

// File: rtl/regfile_write_port.sv
// Write side of the register file: valid/ready write port, sequenced clear,
// and the flattened register bus feeding the read mux.
module regfile_write_port
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_REGS = 2 ** ADDR_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       clr_start,
    output logic                       busy,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat
);
    localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(NUM_REGS - 1);

    rf_state_t                       state;
    logic [ADDR_W-1:0]               cnt;
    logic [NUM_REGS-1:0][DATA_W-1:0] rf;
    logic [NUM_REGS-1:0]             sel;
    logic [ADDR_W-1:0]               dec_addr;
    logic [DATA_W-1:0]               din;
    logic                            dec_en;

    assign busy     = (state == CLEAR);
    assign wr_ready = (state == IDLE) && !clr_start;

    // The clear sequence steals the single decoder input while busy.
    assign dec_addr = busy ? cnt : wr_addr;
    assign dec_en   = busy || (wr_valid && wr_ready);
    assign din      = busy ? '0 : wr_data;

    decoder_5to32 #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_dec (
        .en     (dec_en),
        .addr   (dec_addr),
        .onehot (sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (clr_start) begin
                    state <= CLEAR;
                    cnt   <= CNT_ONE;
                end
                CLEAR: begin
                    if (cnt == CNT_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        // Entry 0 accepts the handshake but always loads zero.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)      rf[i] <= '0;
            else if (sel[i]) rf[i] <= (i == 0) ? '0 : din;
        end
    end

    assign regs_flat = rf;
endmodule

// File: tb/tb_regfile_write_port.sv
// Randomized self-checking bench for regfile_write_port against a register-array model.
module tb_regfile_write_port;
    import rf_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid, clr_start;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_ready, busy;
    logic [32*32-1:0] regs_flat;

    int errors = 0;
    int checks = 0;

    logic [31:0] mdl [32];
    int clr_left;   // registers still to be cleared; 0 means idle

    regfile_write_port dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .clr_start (clr_start),
        .busy      (busy),
        .regs_flat (regs_flat)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dut_reg(int i);
        return regs_flat[i*32 +: 32];
    endfunction

    function automatic logic exp_ready();
        return (clr_left == 0) && !clr_start;
    endfunction

    // Advance one clock edge and apply the behavioural rules to the model.
    task automatic tick();
        @(posedge clk);
        if (clr_left > 0) begin
            mdl[32 - clr_left] = '0;
            clr_left--;
        end else if (clr_start) begin
            clr_left = 31;
        end else if (wr_valid && wr_addr != 0) begin
            mdl[wr_addr] = wr_data;
        end
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        clr_left = 0;
    endtask

    task automatic test_reset();
        wr_valid = 0; clr_start = 0; wr_addr = '0; wr_data = '0;
        rst_n = 0;
        model_reset();
        #12;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++;
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", wr_ready); end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (dut_reg(i) !== 32'd0) begin errors++; $display("FAIL reset_reg%0d got=%h exp=0", i, dut_reg(i)); end
        end
        @(negedge clk);
        rst_n = 1;
        #1;
    endtask

    task automatic test_fill();
        for (int i = 1; i < 32; i++) begin
            wr_valid = 1; wr_addr = 5'(i); wr_data = 32'(10 * i);
            checks++;
            if (wr_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d got=%b exp=1", i, wr_ready); end
            tick();
            checks++;
            if (dut_reg(i) !== 32'(10 * i)) begin errors++; $display("FAIL fill_reg%0d got=%0d exp=%0d", i, dut_reg(i), 10 * i); end
        end
        wr_valid = 0;
        checks++;
        if (dut_reg(0) !== 32'd0) begin errors++; $display("FAIL fill_reg0 got=%h exp=0", dut_reg(0)); end
    endtask

    task automatic test_write_zero();
        wr_valid = 1; wr_addr = 5'd0; wr_data = 32'hDEADBEEF;
        checks++;
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL wz_ready got=%b exp=1", wr_ready); end
        tick();
        wr_valid = 0;
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (dut_reg(i) !== mdl[i]) begin errors++; $display("FAIL wz_reg%0d got=%h exp=%h", i, dut_reg(i), mdl[i]); end
        end
    endtask

    task automatic test_back_to_back();
        wr_valid = 1; wr_addr = 5'd7; wr_data = 32'd70;
        tick();
        wr_data = 32'd700;
        tick();
        wr_valid = 0;
        checks++;
        if (dut_reg(7) !== 32'd700) begin errors++; $display("FAIL b2b_reg7 got=%0d exp=700", dut_reg(7)); end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (dut_reg(i) !== mdl[i]) begin errors++; $display("FAIL b2b_reg%0d got=%h exp=%h", i, dut_reg(i), mdl[i]); end
        end
    endtask

    task automatic test_clear_collision();
        int busy_cycles = 0;
        wr_valid = 1; wr_addr = 5'd3; wr_data = 32'd5; clr_start = 1;
        #1;
        checks++;
        if (wr_ready !== 1'b0) begin errors++; $display("FAIL clr_start_ready got=%b exp=0", wr_ready); end
        tick();
        wr_valid = 0; clr_start = 0;
        checks++;
        if (dut_reg(3) !== 32'd30) begin errors++; $display("FAIL clr_nowrite got=%0d exp=30", dut_reg(3)); end
        while (busy === 1'b1 && busy_cycles < 40) begin
            busy_cycles++;
            checks++;
            if (wr_ready !== 1'b0) begin errors++; $display("FAIL clr_ready_low got=%b exp=0", wr_ready); end
            tick();
        end
        checks++;
        if (busy_cycles != 31) begin errors++; $display("FAIL clr_busy_len got=%0d exp=31", busy_cycles); end
        checks++;
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL clr_ready_back got=%b exp=1", wr_ready); end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (dut_reg(i) !== 32'd0) begin errors++; $display("FAIL clr_reg%0d got=%h exp=0", i, dut_reg(i)); end
        end
    endtask

    task automatic test_reset_mid_clear();
        for (int i = 1; i < 32; i++) begin
            wr_valid = 1; wr_addr = 5'(i); wr_data = $urandom;
            tick();
        end
        wr_valid = 0;
        clr_start = 1;
        tick();
        clr_start = 0;
        for (int k = 0; k < 14; k++) tick();   // counter now at 15
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rmc_busy_before got=%b exp=1", busy); end
        checks++;
        if (dut_reg(20) !== mdl[20]) begin errors++; $display("FAIL rmc_reg20_pending got=%h exp=%h", dut_reg(20), mdl[20]); end
        rst_n = 0;
        model_reset();
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rmc_busy got=%b exp=0", busy); end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (dut_reg(i) !== 32'd0) begin errors++; $display("FAIL rmc_reg%0d got=%h exp=0", i, dut_reg(i)); end
        end
        @(posedge clk);
        #1 rst_n = 1;
        wr_valid = 1; wr_addr = 5'd20; wr_data = 32'h1234_5678;
        checks++;
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL rmc_ready got=%b exp=1", wr_ready); end
        tick();
        wr_valid = 0;
        checks++;
        if (dut_reg(20) !== 32'h1234_5678) begin errors++; $display("FAIL rmc_reg20 got=%h exp=12345678", dut_reg(20)); end
    endtask

    task automatic test_hold_during_clear();
        int guard = 0;
        clr_start = 1;
        tick();
        clr_start = 0;
        wr_valid = 1; wr_addr = 5'd9; wr_data = 32'd90;
        while (wr_ready !== 1'b1 && guard < 40) begin
            guard++;
            checks++;
            if (dut_reg(9) !== 32'd0) begin errors++; $display("FAIL hold_early reg9 got=%0d exp=0", dut_reg(9)); end
            tick();
        end
        checks++;
        if (guard != 31) begin errors++; $display("FAIL hold_wait got=%0d exp=31", guard); end
        checks++;
        if (dut_reg(9) !== 32'd0) begin errors++; $display("FAIL hold_pre reg9 got=%0d exp=0", dut_reg(9)); end
        tick();
        wr_valid = 0;
        checks++;
        if (dut_reg(9) !== 32'd90) begin errors++; $display("FAIL hold_reg9 got=%0d exp=90", dut_reg(9)); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            wr_valid  = ($urandom_range(0, 3) != 0);
            wr_addr   = 5'($urandom_range(0, 31));
            wr_data   = $urandom;
            clr_start = ($urandom_range(0, 59) == 0);
            #1;
            checks++;
            if (wr_ready !== exp_ready()) begin errors++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, wr_ready, exp_ready()); end
            tick();
            checks++;
            if (busy !== (clr_left > 0)) begin errors++; $display("FAIL rnd_busy n=%0d got=%b exp=%b", n, busy, clr_left > 0); end
            for (int i = 0; i < 32; i++) begin
                checks++;
                if (dut_reg(i) !== mdl[i]) begin errors++; $display("FAIL rnd_reg%0d n=%0d got=%h exp=%h", i, n, dut_reg(i), mdl[i]); end
            end
        end
        wr_valid = 0; clr_start = 0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_write_zero();
        test_back_to_back();
        test_clear_collision();
        test_reset_mid_clear();
        test_hold_during_clear();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
